// File: rtl/wb_cmd_master_pkg.sv
// Shared Wishbone definitions: FSM state encoding and bus width / error-data defaults.
package wb_pkg;

   localparam int unsigned WB_AW = 32;
   localparam int unsigned WB_DW = 32;

   // Returned in place of read data when the slave never acknowledges
   localparam logic [31:0] WB_RSP_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic single-transfer bus bundle, master and slave views.
interface wb_cmd_master_if
   import wb_pkg::*;
#(
   parameter int unsigned AW = WB_AW,
   parameter int unsigned DW = WB_DW
) ();

   logic            cyc;
   logic            stb;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_w;   // master -> slave write data
   logic [DW-1:0]   dat_r;   // slave -> master read data
   logic            ack;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  ack, dat_r
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output ack, dat_r
   );

endinterface

// File: rtl/wb_cmd_master_timeout_ctr.sv
// Saturating bus-cycle counter. tc_o flags the last allowed cycle so the
// master can leave BUS on the edge the count reaches TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the terminal count entirely.
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
   localparam bit TC_ENABLE = (TIMEOUT_CYCLES > 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise count up while enabled and hold at the maximum
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This cycle is the last one before the count would hit TIMEOUT_CYCLES
   assign tc_o = TC_ENABLE && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: takes one command over a
// valid/ready handshake, runs one bus cycle with an ack timeout and returns
// one response over a second valid/ready handshake. All outputs are flops.
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int unsigned   AW             = WB_AW,
   parameter int unsigned   DW             = WB_DW,
   parameter int unsigned   TIMEOUT_CYCLES = 255,
   parameter logic [DW-1:0] RSP_ERR_DATA   = DW'(WB_RSP_ERR_DATA)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [AW-1:0]     cmd_adr_i,
   input  logic [DW-1:0]     cmd_dat_i,
   input  logic [DW/8-1:0]   cmd_sel_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DW-1:0]     rsp_dat_o,
   output logic              rsp_err_o,
   wb_cmd_master_if.master   wbm,
   output logic              busy_o
);

   localparam int unsigned SW = DW / 8;

   wb_state_e     state_q,     state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          busy_q,      busy_d;
   logic          cyc_q,       cyc_d;
   logic          stb_q,       stb_d;
   logic          we_q,        we_d;
   logic [SW-1:0] sel_q,       sel_d;
   logic [AW-1:0] adr_q,       adr_d;
   logic [DW-1:0] dat_q,       dat_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_dat_q,   rsp_dat_d;
   logic          rsp_err_q,   rsp_err_d;
   logic          tmo_tc_s;

   wb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk_i   (wb_clk_i),
      .rst_n_i (wb_rst_n_i),
      .clr_i   (state_q != ST_BUS),
      .en_i    (state_q == ST_BUS),
      .tc_o    (tmo_tc_s)
   );

   // Next-state and next-output logic; every output is computed one cycle ahead
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      busy_d      = busy_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               state_d     = ST_BUS;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               we_d        = cmd_we_i;
               sel_d       = cmd_sel_i;
               adr_d       = cmd_adr_i;
               dat_d       = cmd_dat_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUS: begin
            // ack takes priority over a timeout in the same cycle
            if (wbm.ack) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = we_q ? {DW{1'b0}} : wbm.dat_r;
               rsp_err_d   = 1'b0;
            end else if (tmo_tc_s) begin
               state_d     = ST_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = RSP_ERR_DATA;
               rsp_err_d   = 1'b1;
            end else begin
               state_d = ST_BUS;
            end
         end
         ST_RESP: begin
            // cmd_ready only rises after the handshake edge: no bypass into a new command
            if (rsp_ready_i) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= {SW{1'b0}};
         adr_q       <= {AW{1'b0}};
         dat_q       <= {DW{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= {DW{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign busy_o      = busy_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm.cyc     = cyc_q;
   assign wbm.stb     = stb_q;
   assign wbm.we      = we_q;
   assign wbm.sel     = sel_q;
   assign wbm.adr     = adr_q;
   assign wbm.dat_w   = dat_q;

endmodule
